// File: rtl/segment_counter_ctrl.sv
// Two-digit BCD up/down counter with start/pause/clear push-buttons and a tick prescaler.
// Keys are synchronized and debounced; digits update on the edge ending each tick cycle.
module segment_counter_ctrl #(
  parameter int TICK_DIV     = 12_000_000,
  parameter int DEBOUNCE_CYC = 240_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start,
  input  logic       key_clear,
  input  logic       up_down,
  output logic [3:0] seg_data_1,
  output logic [3:0] seg_data_2,
  output logic [1:0] run_state,
  output logic       wrap
);

  localparam int DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int PSW = $clog2(TICK_DIV);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  state_t         state, state_nxt;
  logic [1:0]     keys, sync1, sync2, db, db_d, press;
  logic [DBW-1:0] db_cnt [2];
  logic [PSW-1:0] presc;
  logic           tick, start_p, clear_p;
  logic [3:0]     tens, units, tens_nxt, units_nxt;
  logic           wrap_nxt;

  assign keys = {key_clear, key_start};

  // Bit 0 is start, bit 1 is clear; both idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 2'b11;
      sync2     <= 2'b11;
      db        <= 2'b11;
      db_d      <= 2'b11;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      db_d  <= db;
      for (int k = 0; k < 2; k++) begin
        if (sync2[k] != db[k]) begin
          if (db_cnt[k] == DB_LAST) begin
            db[k]     <= sync2[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + DBW'(1);
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  assign press   = db_d & ~db;
  assign start_p = press[0];
  assign clear_p = press[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear_p) begin
      state_nxt = S_IDLE;
    end else if (start_p) begin
      case (state)
        S_IDLE:  state_nxt = S_RUN;
        S_RUN:   state_nxt = S_PAUSE;
        S_PAUSE: state_nxt = S_RUN;
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE && state != S_RUN && state != S_PAUSE) begin
      state_nxt = S_IDLE;
    end
  end

  assign tick = (state == S_RUN) && (presc == PS_LAST);

  // Prescaler is zeroed while idle and on clear, frozen in pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clear_p || state == S_IDLE) begin
      presc <= '0;
    end else if (state == S_RUN) begin
      presc <= tick ? '0 : presc + PSW'(1);
    end
  end

  // Entering or staying in IDLE overrides any tick, so a clear never wraps.
  always_comb begin
    tens_nxt  = tens;
    units_nxt = units;
    wrap_nxt  = 1'b0;
    if (state_nxt == S_IDLE) begin
      tens_nxt  = 4'd0;
      units_nxt = 4'd0;
    end else if (tick) begin
      if (up_down) begin
        if (units >= 4'd9) begin
          units_nxt = 4'd0;
          if (tens >= 4'd9) begin
            tens_nxt = 4'd0;
            wrap_nxt = 1'b1;
          end else begin
            tens_nxt = tens + 4'd1;
          end
        end else begin
          units_nxt = units + 4'd1;
        end
      end else begin
        if (units == 4'd0) begin
          units_nxt = 4'd9;
          if (tens == 4'd0) begin
            tens_nxt = 4'd9;
            wrap_nxt = 1'b1;
          end else begin
            tens_nxt = tens - 4'd1;
          end
        end else begin
          units_nxt = units - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens  <= 4'd0;
      units <= 4'd0;
      wrap  <= 1'b0;
    end else begin
      tens  <= tens_nxt;
      units <= units_nxt;
      wrap  <= wrap_nxt;
    end
  end

  assign seg_data_1 = tens;
  assign seg_data_2 = units;
  assign run_state  = state;

endmodule

// File: doc/segment_counter_ctrl.md
SEGMENT_COUNTER_CTRL -- requirements
Module: segment_counter_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12_000_000, clk cycles per count tick (1 Hz at 12 MHz); legal range 2..2^24.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 240_000, consecutive stable cycles needed to accept a key level change (20 ms at 12 MHz); legal range 1..2^20.
REQ-003 SHALL have port clk  input  1  system clock; all logic is in this single clock domain.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port key_start  input  1  asynchronous push-button, active-low; start/pause toggle.
REQ-006 SHALL have port key_clear  input  1  asynchronous push-button, active-low; clear to 00.
REQ-007 SHALL have port up_down  input  1  count direction, 1=up, 0=down; quasi-static, sampled only on tick.
REQ-008 SHALL have port seg_data_1  output  4  BCD tens digit to the 7-segment decoder, registered, range 0..9.
REQ-009 SHALL have port seg_data_2  output  4  BCD units digit to the 7-segment decoder, registered, range 0..9.
REQ-010 SHALL have port run_state  output  2  FSM state: 00=IDLE, 01=RUN, 10=PAUSE; 11 never driven.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on 99->00 (up) or 00->99 (down).

Function
REQ-012 Each key SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each key SHALL have a debounced level, initially 1, that takes the synchronized value only after the two have differed for DEBOUNCE_CYC consecutive cycles; any mismatch-free cycle restarts the count.
REQ-014 Each key SHALL produce a one-cycle press pulse in the cycle after its debounced level goes 1->0; release generates no pulse.
REQ-015 FSM transitions SHALL be: IDLE+start->RUN; RUN+start->PAUSE; PAUSE+start->RUN; any state+clear->IDLE.
REQ-016 If clear and start pulses coincide, clear SHALL win and the start pulse SHALL be discarded.
REQ-017 The prescaler SHALL be 0 in IDLE, SHALL increment each cycle in RUN, SHALL hold its value in PAUSE, and SHALL wrap TICK_DIV-1 -> 0 while asserting an internal tick for that cycle.
REQ-018 The first tick after IDLE->RUN SHALL occur exactly TICK_DIV cycles after the RUN state is entered.
REQ-019 On tick with up_down=1: units 9->0 with tens+1; tens 9 and units 9 -> 00 with wrap=1.
REQ-020 On tick with up_down=0: units 0->9 with tens-1; 00 -> 99 with wrap=1.
REQ-021 Digit outputs SHALL update on the clock edge ending the tick cycle; wrap SHALL be asserted in the same cycle the wrapped value first appears.
REQ-022 Entering IDLE SHALL set both digits to 0 on the same edge that sets run_state=00.
REQ-023 A clear arriving in the same cycle as a tick SHALL win: digits go to 00 and wrap stays 0.
REQ-024 Digits SHALL never leave 0..9 (no BCD values 10..15).
REQ-025 PAUSE SHALL hold the digits and prescaler unchanged; RUN SHALL resume from the held prescaler value.

Reset
REQ-026 rst_n=0 SHALL immediately set run_state=00, seg_data_1=0, seg_data_2=0, wrap=0, prescaler=0, synchronizers and debounced levels=1, and debounce counters=0.
REQ-027 Reset assertion mid-count SHALL abort the operation with no residual tick or press pulse after release.
REQ-028 After rst_n deasserts, the first press SHALL require full synchronization and debounce.

Verification (TICK_DIV=4, DEBOUNCE_CYC=3)
REQ-029 Reset then press start (hold low 10 cycles): run_state 00->01; after 4, 8 and 12 cycles in RUN, digits read 01, 02 and 03.
REQ-030 RUN up at 99, tick: digits 00 and wrap=1 for exactly one cycle; with up_down=0 at 00, tick: digits 99 and wrap=1.
REQ-031 start glitch low for 2 cycles, then high: no state change; held low 3 or more cycles: exactly one toggle, and release causes none.
REQ-032 RUN at 05 with prescaler=2, press start: PAUSE; the digits hold 05 for 50 cycles; press start again: RUN, and the next tick comes 2 cycles after RUN is re-entered (06).
REQ-033 Clear and start pulses in the same cycle, or clear coinciding with a tick: run_state=00, digits 00, wrap=0.
REQ-034 rst_n pulse low while in RUN at 47: all outputs 0 asynchronously, no change until a new debounced press.
